// File: rtl/oh_or_accum_pkg.sv
// Shared elaboration limits for the masked OR-reduce / accumulate block.
package oh_or_accum_pkg;

  localparam int N_MIN  = 2;
  localparam int PS_MAX = 4;

endpackage : oh_or_accum_pkg

// File: rtl/oh_or_accum_if.sv
// Channel/control bundle into oh_or_accum and the registered result coming back.
interface oh_or_accum_if #(
  parameter int DW = 8,
  parameter int N  = 4
);

  logic [N*DW-1:0] in;
  logic [N-1:0]    mask;
  logic            valid_in;
  logic            sticky;
  logic            clear;
  logic [DW-1:0]   z;
  logic            valid_out;
  logic            any;

  modport master (
    output in, mask, valid_in, sticky, clear,
    input  z, valid_out, any
  );

  modport slave (
    input  in, mask, valid_in, sticky, clear,
    output z, valid_out, any
  );

endinterface : oh_or_accum_if

// File: rtl/oh_pipe_stage.sv
// One {valid, data} pipeline register; data only moves when the incoming valid is set.
module oh_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  // NOTE: data registers are reset as well, so a discarded in-flight result can never resurface.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : oh_pipe_stage

// File: rtl/oh_or_accum.sv
// Masked N-channel OR reduction, PS pipeline stages, then a pass-through/sticky accumulator.
module oh_or_accum
  import oh_or_accum_pkg::*;
#(
  parameter int DW = 8,
  parameter int N  = 4,
  parameter int PS = 1
) (
  input  logic         clk,
  input  logic         nreset,
  oh_or_accum_if.slave bus
);

  if (N < N_MIN || PS < 0 || PS > PS_MAX) begin : g_bad_params
    $fatal(1, "oh_or_accum: N must be >= %0d and PS within 0..%0d", N_MIN, PS_MAX);
  end

  logic [DW-1:0]         w_r;
  logic [PS:0]           w_v;
  logic [PS:0][DW-1:0]   w_d;
  logic                  w_av;
  logic [DW-1:0]         w_ar;
  logic [DW-1:0]         w_z_next;
  logic [DW-1:0]         r_z;
  logic                  r_valid_out;
  logic                  r_any;

  // NOTE: assigning a default before the loop leaves no path that holds a value, so no latch.
  always_comb begin
    w_r = '0;
    for (int k = 0; k < N; k++) begin
      w_r = w_r | (bus.in[k*DW +: DW] & {DW{~bus.mask[k]}});
    end
  end

  assign w_v[0] = bus.valid_in;
  assign w_d[0] = w_r;

  for (genvar s = 0; s < PS; s++) begin : g_stage
    oh_pipe_stage #(.DW(DW)) u_stage (
      .clk     (clk),
      .nreset  (nreset),
      .i_valid (w_v[s]),
      .i_data  (w_d[s]),
      .o_valid (w_v[s+1]),
      .o_data  (w_d[s+1])
    );
  end

  assign w_av = w_v[PS];
  assign w_ar = w_d[PS];

  // Clear wins over sticky, but a result arriving with the clear still lands in z.
  always_comb begin
    w_z_next = r_z;
    if (bus.clear) begin
      w_z_next = w_av ? w_ar : '0;
    end else if (w_av) begin
      w_z_next = bus.sticky ? (r_z | w_ar) : w_ar;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_z         <= '0;
      r_valid_out <= 1'b0;
      r_any       <= 1'b0;
    end else begin
      r_z         <= w_z_next;
      r_valid_out <= w_av;
      r_any       <= |w_z_next;
    end
  end

  assign bus.z         = r_z;
  assign bus.valid_out = r_valid_out;
  assign bus.any       = r_any;

endmodule : oh_or_accum

// File: tb/tb_oh_or_accum.sv
// Drives PS=0, PS=2 and PS=4 builds with one shared stimulus and checks each at its own latency.
module tb_oh_or_accum;

  localparam int DW = 8;
  localparam int N  = 4;

  typedef struct {
    logic [31:0] vin;
    logic [3:0]  vmask;
    logic [7:0]  exp;
  } vec_t;

  logic            clk    = 1'b0;
  logic            nreset = 1'b0;
  logic [N*DW-1:0] s_in;
  logic [N-1:0]    s_mask;
  logic            s_valid;
  logic            s_sticky;
  logic [2:0]      s_clear;

  logic [DW-1:0]   w_z [3];
  logic [2:0]      w_vo;
  logic [2:0]      w_any;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar d = 0; d < 3; d++) begin : g_dut
    oh_or_accum_if #(.DW(DW), .N(N)) u_if ();

    assign u_if.in       = s_in;
    assign u_if.mask     = s_mask;
    assign u_if.valid_in = s_valid;
    assign u_if.sticky   = s_sticky;
    assign u_if.clear    = s_clear[d];
    assign w_z[d]        = u_if.z;
    assign w_vo[d]       = u_if.valid_out;
    assign w_any[d]      = u_if.any;

    oh_or_accum #(.DW(DW), .N(N), .PS(2*d)) u_dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (u_if)
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_dut(input int d, input string tag, input int k,
                         input logic [7:0] ez, input logic evo);
    check($sformatf("%s[%0d] ps%0d z", tag, k, 2*d), 32'(w_z[d]), 32'(ez));
    check($sformatf("%s[%0d] ps%0d valid_out", tag, k, 2*d), 32'(w_vo[d]), 32'(evo));
    check($sformatf("%s[%0d] ps%0d any", tag, k, 2*d), 32'(w_any[d]), 32'(|ez));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One valid beat; each build must show it exactly PS+1 cycles after it was driven.
  task automatic run_single(input string tag, input logic [31:0] vin, input logic [3:0] vmask,
                            input logic [7:0] prev, input logic [7:0] exp);
    s_in    = vin;
    s_mask  = vmask;
    s_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      s_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        if (k < 2*d)       chk_dut(d, tag, k, prev, 1'b0);
        else if (k == 2*d) chk_dut(d, tag, k, exp, 1'b1);
        else               chk_dut(d, tag, k, exp, 1'b0);
      end
    end
  endtask

  vec_t       vecs [6];
  logic [7:0] seq  [3];
  logic [7:0] cum  [3];
  logic [7:0] prev;

  initial begin
    vecs[0] = '{32'h80041001, 4'b0100, 8'h91};
    vecs[1] = '{32'h80041001, 4'b1111, 8'h00};
    vecs[2] = '{32'h01020408, 4'b0000, 8'h0F};
    vecs[3] = '{32'hFF00AA55, 4'b1001, 8'hAA};
    vecs[4] = '{32'hFFFFFFFF, 4'b1110, 8'hFF};
    vecs[5] = '{32'h00000000, 4'b0000, 8'h00};
    seq = '{8'h01, 8'h02, 8'h40};
    cum = '{8'h01, 8'h03, 8'h43};

    s_in     = 32'hDEADBEEF;
    s_mask   = '0;
    s_valid  = 1'b1;
    s_sticky = 1'b0;
    s_clear  = '0;

    // Reset held with valid traffic present: outputs stay zero.
    repeat (3) begin
      tick();
      for (int d = 0; d < 3; d++) chk_dut(d, "rst_hold", 0, 8'h00, 1'b0);
    end

    // Release with valid still high: first valid_out PS+1 cycles later.
    s_in   = 32'h11223344;
    nreset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int d = 0; d < 3; d++)
        chk_dut(d, "rst_release", k, (k >= 2*d) ? 8'h77 : 8'h00, k >= 2*d);
    end
    s_valid = 1'b0;
    repeat (6) tick();
    for (int d = 0; d < 3; d++) chk_dut(d, "drain", 0, 8'h77, 1'b0);

    // Pass-through table.
    prev = 8'h77;
    for (int v = 0; v < 6; v++) begin
      run_single($sformatf("vec%0d", v), vecs[v].vin, vecs[v].vmask, prev, vecs[v].exp);
      prev = vecs[v].exp;
    end

    // Clear with nothing arriving.
    s_clear = 3'b111;
    tick();
    s_clear = '0;
    for (int d = 0; d < 3; d++) chk_dut(d, "clear_idle", 0, 8'h00, 1'b0);

    // Sticky accumulation over back-to-back beats, then five idle cycles.
    s_sticky = 1'b1;
    s_mask   = '0;
    for (int k = 0; k < 12; k++) begin
      s_valid = (k < 3);
      s_in    = (k < 3) ? {24'h0, seq[k]} : 32'h0;
      tick();
      for (int d = 0; d < 3; d++) begin
        if (k < 2*d)            chk_dut(d, "sticky", k, 8'h00, 1'b0);
        else if (k - 2*d < 3)   chk_dut(d, "sticky", k, cum[k-2*d], 1'b1);
        else                    chk_dut(d, "sticky", k, 8'h43, 1'b0);
      end
    end
    s_valid = 1'b0;

    // Clear alone against z=0x43.
    s_clear = 3'b111;
    tick();
    s_clear = '0;
    for (int d = 0; d < 3; d++) chk_dut(d, "clear_alone", 0, 8'h00, 1'b0);

    run_single("reload", 32'h00000043, 4'b0000, 8'h00, 8'h43);

    // Clear coincident with an arriving 0x08: result replaces z instead of OR-ing.
    s_in    = 32'h00000008;
    s_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int d = 0; d < 3; d++) s_clear[d] = (k == 2*d);
      tick();
      s_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        if (k < 2*d)       chk_dut(d, "clear_hit", k, 8'h43, 1'b0);
        else if (k == 2*d) chk_dut(d, "clear_hit", k, 8'h08, 1'b1);
        else               chk_dut(d, "clear_hit", k, 8'h08, 1'b0);
      end
    end
    s_clear = '0;

    // Dropping sticky keeps z until the next result, which then replaces it.
    s_sticky = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) chk_dut(d, "sticky_off", 0, 8'h08, 1'b0);
    run_single("pass_after_sticky", 32'h00000020, 4'b0000, 8'h08, 8'h20);

    // Reset one cycle after two beats: PS=2 and PS=4 never emit them.
    s_valid = 1'b1;
    s_in    = 32'h00000001;
    tick();
    s_in    = 32'h00000002;
    tick();
    s_valid = 1'b0;
    nreset  = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk_dut(d, "midrst_async", 0, 8'h00, 1'b0);
    repeat (2) tick();
    nreset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      for (int d = 1; d < 3; d++) chk_dut(d, "midrst_after", k, 8'h00, 1'b0);
    end
    check("midrst ps0 z", 32'(w_z[0]), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_oh_or_accum

// File: doc/oh_or_accum.md
Name: oh_or_accum

Overview:
- Parametrised successor to the 2-input OR gate.
- Reduces N channels of DW-bit data with per-channel masking through a configurable register pipeline.
- Ends in an output register that either passes each result through or accumulates it (sticky OR) until cleared.
- Used for interrupt/error-flag aggregation and wide status collection where timing needs pipelining.

Parameters:
- DW, 8: bit width of each channel and of the result.
- N, 4: number of input channels, N >= 2.
- PS, 1: pipeline register stages between the input and the accumulator, 0..4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nreset  input  1  asynchronous active-low reset.
- in  input  N*DW  packed channels; channel k = in[k*DW +: DW].
- mask  input  N  1 = channel k is excluded from the reduction.
- valid_in  input  1  qualifies in/mask this cycle.
- sticky  input  1  accumulator mode: 1 = accumulate OR, 0 = pass-through; sampled at the accumulator stage.
- clear  input  1  synchronous clear of the accumulator; acts at the accumulator stage, not pipelined.
- z  output  DW  accumulator/result register.
- valid_out  output  1  high for one cycle when z was loaded or updated from a valid result.
- any  output  1  registered, equals |z.

Behaviour:
- Reset (nreset low, asynchronous): all pipeline data and valid bits are cleared. z=0, valid_out=0, any=0. Release is synchronous to the next edge.
- Reduction: r = OR over k of (in_k & {DW{~mask[k]}}). Purely combinational from in/mask. All channels masked gives r=0.
- Pipeline: PS stages of {valid, data}.
  - Data registers load only when the incoming valid=1 and otherwise hold.
  - Valid bits load every cycle.
  - PS=0 means r feeds the accumulator directly.
- Accumulator input: ar/av = output of the last stage (or r/valid_in when PS=0).
- Accumulator update, highest priority first:
  - clear=1, av=1: z <= ar.
  - clear=1, av=0: z <= 0.
  - clear=0, av=1, sticky=1: z <= z | ar.
  - clear=0, av=1, sticky=0: z <= ar.
  - clear=0, av=0: z holds.
- valid_out <= av (regardless of clear and sticky).
- any <= |(next value of z), so any is always consistent with z in the same cycle.
- Latency: valid_in to valid_out/z is PS+1 cycles. Throughput is one result per cycle, with no stalls.
- In-flight data is unaffected by clear. A clear while results are in the pipeline empties z, and later results still arrive and update z.
- A sticky change takes effect on the next accumulator update; the prior z value is retained.
- Reset mid-operation: all in-flight results are discarded and no valid_out is produced for them.
- Elaboration check: N<2 or PS outside 0..4 raises a fatal error.

Decomposition:
- No shared package types are needed. Parameter limits (PS_MAX=4) go in the stdlib constants include.
- One sub-module, oh_pipe_stage: DW data plus valid register with async active-low reset and valid-gated data load. It is instantiated PS times via generate.
- Reduction and accumulator logic stay in the top module.

Test Plan:
- Reset: hold nreset=0 with valid_in=1 and arbitrary in -> z=0x00, valid_out=0, any=0 throughout. First valid_out appears PS+1 cycles after release.
- Masked reduction, pass-through (DW=8, N=4, PS=2, sticky=0):
  - Stimulus: in = {0x80,0x04,0x10,0x01} (ch3..ch0), mask=4'b0100.
  - Expected: z=0x91 and valid_out=1 exactly 3 cycles later; any=1.
  - With mask=4'b1111: z=0x00, any=0.
- Sticky accumulation: sticky=1, three consecutive valids with single-channel values 0x01, 0x02, 0x40 -> z steps 0x01, 0x03, 0x43 on consecutive cycles. It then holds 0x43 through 5 idle cycles with valid_out=0.
- Clear collisions, sticky=1 with z=0x43:
  - clear alone -> z=0x00, any=0.
  - clear in the same cycle as av=1 with ar=0x08 -> z=0x08, not 0x4B.
- PS=0 and PS=4 builds: the same stimulus gives an identical z sequence, shifted by 1 and 5 cycles respectively. Back-to-back valids produce back-to-back valid_out with no bubbles.
- Mid-flight reset: PS=2, assert nreset=0 one cycle after two valids -> no valid_out ever appears for them, and z=0 after reset.
